// File: rtl/spi_ram_cmd_ctrl_if.sv
// Command/response bundle between the SPI slave, spi_ram_cmd_ctrl and reg_file.
// Signal names follow the controller's view: i_* flow into it, o_* flow out of it.
interface spi_ram_cmd_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 8
);
    logic [DATA_WIDTH+1:0]   i_rx_data;
    logic                    i_rx_valid;
    logic [ADDRESS_SIZE-1:0] o_address;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_wr_en;
    logic [DATA_WIDTH-1:0]   i_rd_data;
    logic [DATA_WIDTH-1:0]   o_tx_data;
    logic                    o_tx_valid;
    logic                    o_busy;
    logic                    o_drop;

    modport slave (
        input  i_rx_data, i_rx_valid, i_rd_data,
        output o_address, o_data, o_wr_en, o_tx_data, o_tx_valid, o_busy, o_drop
    );

    modport master (
        output i_rx_data, i_rx_valid, i_rd_data,
        input  o_address, o_data, o_wr_en, o_tx_data, o_tx_valid, o_busy, o_drop
    );
endinterface

// File: rtl/spi_ram_cmd_ctrl.sv
// Decodes opcode frames from the SPI slave into reg_file writes/reads with separate
// auto-incrementing write and read pointers; every output is registered.
module spi_ram_cmd_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 8,
    parameter int AUTO_INC     = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_ram_cmd_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [ADDRESS_SIZE-1:0] PTR_STEP = (AUTO_INC != 0) ? ADDRESS_SIZE'(1) : '0;

    logic [1:0]              state_q,   state_d;
    logic [ADDRESS_SIZE-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q,  rd_ptr_d;
    logic [DATA_WIDTH-1:0]   payload_q, payload_d;
    logic [ADDRESS_SIZE-1:0] addr_q,    addr_d;
    logic                    wr_en_q,   wr_en_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q,    busy_d;
    logic                    drop_q,    drop_d;

    logic [1:0]              opcode;
    logic [DATA_WIDTH-1:0]   rx_payload;

    assign opcode     = bus.i_rx_data[DATA_WIDTH+1:DATA_WIDTH];
    assign rx_payload = bus.i_rx_data[DATA_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        payload_d = payload_q;
        tx_data_d = tx_data_q;
        drop_d    = bus.i_rx_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    case (opcode)
                        OP_WR_ADDR: wr_ptr_d = rx_payload[ADDRESS_SIZE-1:0];
                        OP_RD_ADDR: rd_ptr_d = rx_payload[ADDRESS_SIZE-1:0];
                        OP_WR_DATA: begin
                            payload_d = rx_payload;
                            state_d   = WRITE;
                        end
                        default:    state_d = READ;
                    endcase
                end
            end
            WRITE: begin
                wr_ptr_d = wr_ptr_q + PTR_STEP;
                state_d  = IDLE;
            end
            READ: begin
                tx_data_d = bus.i_rd_data;
                rd_ptr_d  = rd_ptr_q + PTR_STEP;
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        addr_d     = (state_d == WRITE) ? wr_ptr_d : rd_ptr_d;
        wr_en_d    = (state_d == WRITE);
        tx_valid_d = (state_d == RESP);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            payload_q  <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            payload_q  <= payload_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.o_address  = addr_q;
    assign bus.o_data     = payload_q;
    assign bus.o_wr_en    = wr_en_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_drop     = drop_q;
endmodule
